// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Purpose  : One-shot core load/store to APB SETUP/ACCESS master with watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter int BUS_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 core_req,
    input  logic                 core_we,
    input  logic [BUS_WIDTH-1:0] core_addr,
    input  logic [BUS_WIDTH-1:0] core_wdata,
    output logic [BUS_WIDTH-1:0] core_rdata,
    output logic                 core_done,
    output logic                 core_err,
    output logic                 core_busy,
    output logic [BUS_WIDTH-1:0] M_PADDR,
    output logic                 M_PWRITE,
    output logic                 M_PSELx,
    output logic                 M_PENABLE,
    output logic [BUS_WIDTH-1:0] M_PWDATA,
    input  logic [BUS_WIDTH-1:0] M_PRDATA,
    input  logic                 M_PREADY
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [TO_WIDTH-1:0] C_WD_ONE  = TO_WIDTH'(1);
    localparam logic [TO_WIDTH-1:0] C_WD_MAX  = '1;
    localparam logic [TO_WIDTH-1:0] C_TIMEOUT = TO_WIDTH'(TIMEOUT_CYCLES);
    localparam bit                  C_WD_EN   = (TIMEOUT_CYCLES != 0);

    state_t               r_state;
    logic [BUS_WIDTH-1:0] r_addr;
    logic [BUS_WIDTH-1:0] r_wdata;
    logic [BUS_WIDTH-1:0] r_rdata;
    logic                 r_we;
    logic                 r_psel;
    logic                 r_penable;
    logic                 r_done;
    logic                 r_err;
    logic                 r_busy;
    logic [TO_WIDTH-1:0]  r_wd_cnt;

    logic [TO_WIDTH-1:0]  w_wd_next;
    logic                 w_timeout;

    // Saturating increment so a disabled watchdog can never wrap around
    assign w_wd_next = (r_wd_cnt == C_WD_MAX) ? r_wd_cnt : (r_wd_cnt + C_WD_ONE);
    assign w_timeout = C_WD_EN && (w_wd_next == C_TIMEOUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_we      <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_wd_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (core_req) begin
                        r_state <= S_SETUP;
                        r_addr  <= core_addr;
                        r_we    <= core_we;
                        r_wdata <= core_we ? core_wdata : '0;
                        r_psel  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                end
                S_ACCESS: begin
                    // PREADY wins over a timeout landing on the same edge
                    if (M_PREADY) begin
                        r_state   <= S_DONE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= M_PRDATA;
                        end
                    end else begin
                        r_wd_cnt <= w_wd_next;
                        if (w_timeout) begin
                            r_state   <= S_DONE;
                            r_psel    <= 1'b0;
                            r_penable <= 1'b0;
                            r_done    <= 1'b1;
                            r_err     <= 1'b1;
                            if (!r_we) begin
                                r_rdata <= '0;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_done   <= 1'b0;
                    r_err    <= 1'b0;
                    r_busy   <= 1'b0;
                    r_wd_cnt <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign core_rdata = r_rdata;
    assign core_done  = r_done;
    assign core_err   = r_err;
    assign core_busy  = r_busy;
    assign M_PADDR    = r_addr;
    assign M_PWRITE   = r_we;
    assign M_PSELx    = r_psel;
    assign M_PENABLE  = r_penable;
    assign M_PWDATA   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Purpose  : Randomized transfers against a transaction-level bridge model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int BW = 16;
    localparam int TO = 4;

    logic          clk;
    logic          reset;
    logic          core_req;
    logic          core_we;
    logic [BW-1:0] core_addr;
    logic [BW-1:0] core_wdata;
    logic [BW-1:0] core_rdata;
    logic          core_done;
    logic          core_err;
    logic          core_busy;
    logic [BW-1:0] M_PADDR;
    logic          M_PWRITE;
    logic          M_PSELx;
    logic          M_PENABLE;
    logic [BW-1:0] M_PWDATA;
    logic [BW-1:0] M_PRDATA;
    logic          M_PREADY;

    int checks = 0;
    int fails  = 0;

    apb_master_bridge #(
        .BUS_WIDTH      (BW),
        .TIMEOUT_CYCLES (TO),
        .TO_WIDTH       (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_done  (core_done),
        .core_err   (core_err),
        .core_busy  (core_busy),
        .M_PADDR    (M_PADDR),
        .M_PWRITE   (M_PWRITE),
        .M_PSELx    (M_PSELx),
        .M_PENABLE  (M_PENABLE),
        .M_PWDATA   (M_PWDATA),
        .M_PRDATA   (M_PRDATA),
        .M_PREADY   (M_PREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction model: a transfer is "in flight" from acceptance; age counts
    // cycles since acceptance, and it ends with exactly one done cycle.
    bit            m_in, m_done, m_err, m_we;
    int            m_age, m_waits;
    logic [BW-1:0] m_addr, m_wdata, m_rdata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_in = 0; m_done = 0; m_err = 0; m_we = 0;
            m_age = 0; m_waits = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else if (m_done) begin
            m_in = 0; m_done = 0; m_err = 0;
        end else if (m_in) begin
            if (m_age >= 2) begin
                if (M_PREADY) begin
                    m_done = 1; m_err = 0;
                    if (!m_we) m_rdata = M_PRDATA;
                end else begin
                    m_waits = m_waits + 1;
                    if (m_waits == TO) begin
                        m_done = 1; m_err = 1;
                        if (!m_we) m_rdata = '0;
                    end
                end
            end
            m_age = m_age + 1;
        end else if (core_req) begin
            m_in = 1; m_age = 1; m_waits = 0;
            m_we = core_we; m_addr = core_addr;
            m_wdata = core_we ? core_wdata : '0;
        end
    end

    always @(negedge clk) begin
        logic [53:0] act, exp;
        act = {core_busy, core_done, core_err, M_PSELx, M_PENABLE, M_PWRITE,
               M_PADDR, M_PWDATA, core_rdata};
        exp = {m_in, m_done, m_done && m_err, m_in && !m_done,
               m_in && !m_done && (m_age >= 2), m_we, m_addr, m_wdata, m_rdata};
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL cycle_model t=%0t act=%h exp=%h (busy,done,err,psel,pen,pwrite,paddr,pwdata,rdata)",
                     $time, act, exp);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Drive one transfer from an IDLE cycle; waits = not-ready ACCESS cycles
    // (>= TO means timeout). Returns in the IDLE cycle after DONE.
    task automatic xfer(input bit we, input logic [BW-1:0] a, input logic [BW-1:0] wd,
                        input logic [BW-1:0] rd, input int waits, input bit noise,
                        output int ndone, output bit err_seen, output int kdone);
        int total;
        total = (waits >= TO) ? (2 + TO) : (3 + waits);
        ndone = 0; err_seen = 0; kdone = 0;
        core_req = 1'b1; core_we = we; core_addr = a; core_wdata = wd;
        M_PREADY = 1'($urandom_range(0, 1)); M_PRDATA = 16'($urandom);
        for (int k = 1; k <= total + 1; k++) begin
            @(posedge clk); #2;
            if (core_done) begin ndone++; err_seen = core_err; kdone = k; end
            if (noise && k <= total) begin
                core_req = 1'($urandom_range(0, 1)); core_we = 1'($urandom_range(0, 1));
                core_addr = 16'($urandom); core_wdata = 16'($urandom);
            end else begin
                core_req = 1'b0;
            end
            if (k >= 2 && k < total) begin
                M_PREADY = ((k - 2) < waits) ? 1'b0 : 1'b1;
                M_PRDATA = M_PREADY ? rd : 16'($urandom);
            end else begin
                M_PREADY = 1'($urandom_range(0, 1)); M_PRDATA = 16'($urandom);
            end
        end
        core_req = 1'b0;
    endtask

    initial begin
        int nd, kd, w;
        bit es, we;
        logic [BW-1:0] rd;
        reset = 1'b1; core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        M_PRDATA = '0; M_PREADY = 1'b0;
        repeat (2) @(posedge clk); #2;
        chk("reset_state", {core_busy, core_done, core_err, M_PSELx, M_PENABLE, M_PWRITE,
                            M_PADDR, M_PWDATA, core_rdata}, 64'h0);
        reset = 1'b0;
        @(posedge clk); #2;

        xfer(0, 16'h0085, 16'h1111, 16'hBEEF, 0, 0, nd, es, kd);
        chk("rd0_latency", 64'(kd), 64'd3);
        chk("rd0_ndone", 64'(nd), 64'd1);
        chk("rd0_err", 64'(es), 64'd0);
        chk("rd0_rdata", 64'(core_rdata), 64'hBEEF);

        xfer(1, 16'h00A0, 16'h005A, 16'h7777, 3, 0, nd, es, kd);
        chk("wr3_latency", 64'(kd), 64'd6);
        chk("wr3_err", 64'(es), 64'd0);
        chk("wr3_rdata_kept", 64'(core_rdata), 64'hBEEF);
        chk("wr3_bus_hold", {M_PADDR, M_PWRITE, M_PWDATA}, {16'h00A0, 1'b1, 16'h005A});

        xfer(0, 16'h0200, 16'h0000, 16'hFFFF, 6, 0, nd, es, kd);
        chk("to_latency", 64'(kd), 64'd6);
        chk("to_err", 64'(es), 64'd1);
        chk("to_rdata", 64'(core_rdata), 64'h0);
        chk("to_err_idle", 64'(core_err), 64'd0);

        xfer(0, 16'h0120, 16'h0000, 16'h1234, 3, 0, nd, es, kd);
        chk("edge_ready_err", 64'(es), 64'd0);
        chk("edge_ready_rdata", 64'(core_rdata), 64'h1234);

        xfer(1, 16'h0044, 16'hCAFE, 16'h0000, 2, 1, nd, es, kd);
        chk("noise_ndone", 64'(nd), 64'd1);
        xfer(0, 16'h0046, 16'h0000, 16'hD00D, 0, 0, nd, es, kd);
        chk("b2b_latency", 64'(kd), 64'd3);

        // Reset asserted mid-ACCESS
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0300; M_PREADY = 1'b0;
        @(posedge clk); #2; core_req = 1'b0;
        @(posedge clk); #2;
        chk("pre_reset_access", {M_PSELx, M_PENABLE}, 2'b11);
        reset = 1'b1; #1;
        chk("async_reset_release", {M_PSELx, M_PENABLE, core_busy, core_done}, 4'b0000);
        @(posedge clk); #2; reset = 1'b0;
        @(posedge clk); #2;
        xfer(0, 16'h00B0, 16'h0000, 16'h4C4C, 1, 0, nd, es, kd);
        chk("post_reset_rdata", 64'(core_rdata), 64'h4C4C);
        chk("post_reset_ndone", 64'(nd), 64'd1);

        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            w  = $urandom_range(0, 6);
            rd = 16'($urandom);
            xfer(we, 16'($urandom), 16'($urandom), rd, w, 1'($urandom_range(0, 1)), nd, es, kd);
            chk("rand_ndone", 64'(nd), 64'd1);
            chk("rand_latency", 64'(kd), (w >= TO) ? 64'(2 + TO) : 64'(3 + w));
            chk("rand_err", 64'(es), (w >= TO) ? 64'd1 : 64'd0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Single-initiator APB master that turns a core's one-shot load/store request into a compliant APB SETUP/ACCESS transfer. It drives one master port of the APB interconnect and waits on PREADY. It returns read data, a completion pulse and an error flag to the core. A watchdog counter terminates transfers to slaves that never respond, for example unmapped addresses that no slave decodes.

Parameters:
BUS_WIDTH, 16, width of address and data buses
TIMEOUT_CYCLES, 255, maximum ACCESS cycles before forced termination; 0 disables the watchdog
TO_WIDTH, 8, width of watchdog counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
core_req  input  1  single-cycle request strobe, sampled only in IDLE
core_we  input  1  1 = write, 0 = read; qualified by core_req
core_addr  input  BUS_WIDTH  transfer address; qualified by core_req
core_wdata  input  BUS_WIDTH  write data; qualified by core_req
core_rdata  output  BUS_WIDTH  read data of last completed read
core_done  output  1  one-cycle completion pulse
core_err  output  1  timeout indication, valid only while core_done=1
core_busy  output  1  high whenever state != IDLE
M_PADDR  output  BUS_WIDTH  APB address
M_PWRITE  output  1  APB write strobe
M_PSELx  output  1  APB select toward interconnect
M_PENABLE  output  1  APB enable
M_PWDATA  output  BUS_WIDTH  APB write data
M_PRDATA  input  BUS_WIDTH  APB read data
M_PREADY  input  1  APB ready from interconnect

Behaviour:
Reset (asynchronous, takes effect immediately):
- State is IDLE and all outputs are 0, including core_rdata and the watchdog counter.

States: IDLE, SETUP, ACCESS, DONE.
- IDLE -> SETUP: taken when core_req=1 at a rising edge.
  - addr, we and wdata are latched into internal registers.
  - On a read, the wdata register is cleared to 0.
- SETUP, exactly one cycle: M_PSELx=1, M_PENABLE=0. Next state is ACCESS.
- ACCESS: M_PSELx=1, M_PENABLE=1.
  - M_PREADY=1 sampled at an edge: goes to DONE. On a read, core_rdata is loaded from M_PRDATA at that edge. err is cleared.
  - Otherwise the watchdog increments. If TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES, goes to DONE with err=1. On a read, core_rdata is loaded with 0.
- DONE, exactly one cycle: core_done=1, core_err=err, M_PSELx=0, M_PENABLE=0. Next state is IDLE. The watchdog is cleared.

Bus stability:
- M_PADDR, M_PWRITE and M_PWDATA are driven from the latched registers.
- They are stable from SETUP through the final ACCESS cycle, and hold their values in DONE and IDLE.
- M_PENABLE never rises without M_PSELx having been high for the preceding cycle.

Latency:
- Request at edge N: SETUP in cycle N+1, ACCESS in N+2. With zero wait states, done is high in N+3.
- Each cycle of M_PREADY=0 adds one cycle.

Request handling:
- core_req is ignored in SETUP, ACCESS and DONE; it is not queued.
- A req in the IDLE cycle that immediately follows DONE is accepted, giving back-to-back transfers with one idle cycle between them.

Output holding:
- core_rdata is unchanged by writes. It holds its value until the next read completes.
- core_err is 0 whenever core_done=0.

Watchdog:
- The counter saturates and never wraps.
- The timeout comparison has priority below M_PREADY. If M_PREADY=1 on the same edge the limit is reached, the transfer completes normally with err=0.

Reset mid-transfer:
- The bus is released immediately and no core_done is produced.

Test Plan:
- Read 0x0085, M_PREADY tied 1, M_PRDATA=0xBEEF: PSEL rises N+1, PENABLE N+2, core_done N+3, core_rdata=0xBEEF, core_err=0.
- Write 0x00A0 data 0x005A with 3 wait states: PADDR=0x00A0, PWRITE=1, PWDATA=0x005A stable for the full 5-cycle transfer; core_done at N+6; core_rdata unchanged.
- Read 0x0200 with M_PREADY stuck 0 and TIMEOUT_CYCLES=4: four ACCESS cycles, then core_done=1 with core_err=1 and core_rdata=0x0000; next IDLE has core_err=0.
- core_req pulsed during ACCESS of a prior transfer: ignored, with exactly one core_done. A req on the cycle after DONE gives a new SETUP on the following cycle.
- Assert reset during ACCESS: PSEL, PENABLE and core_busy go to 0 within the same cycle; no core_done; a subsequent read 0x00B0 completes normally.
- M_PREADY rises on the same edge the watchdog reaches TIMEOUT_CYCLES with M_PRDATA=0x1234: core_err=0 and core_rdata=0x1234.
